// File: rtl/chk_pkg.sv
// Shared types and helpers for the rose-to-rose property checker.
package chk_pkg;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_PASS = 2'd1,
    RES_FAIL = 2'd2,
    RES_VAC  = 2'd3
  } res_e;

  // Counters are widened to this size for the shared increment, so CNT_W must not exceed it.
  localparam int SAT_W = 32;

  // Increment that sticks at max_val instead of wrapping to zero.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] cnt,
                                               input logic [SAT_W-1:0] max_val);
    return (cnt >= max_val) ? cnt : cnt + SAT_W'(1);
  endfunction

endpackage

// File: rtl/rose_prop_checker_rose_det.sv
// Rising-edge detector: registered previous value, cleared by sync reset so a
// high input on the first cycle after reset counts as a rise.
module rose_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rose
);

  logic d_q;

  // Previous-cycle copy of the input.
  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rose = d & ~d_q;

endmodule

// File: rtl/rose_prop_checker.sv
// Evaluates $rose(a) |-> ##DLY $rose(b) (implication) and $rose(a) #-# ##DLY $rose(b)
// (followed-by) once per enabled cycle, with registered verdicts and saturating counters.
// Optional feature: define CHK_VACUOUS_CNT_EN to add the impl_vac port and its counter.
module rose_prop_checker
  import chk_pkg::*;
#(
  parameter int DLY   = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  output logic             res_vld,
  output logic [1:0]       impl_res,
  output logic [1:0]       fb_res,
  output logic [CNT_W-1:0] impl_pass,
  output logic [CNT_W-1:0] impl_fail,
  output logic [CNT_W-1:0] fb_pass,
`ifdef CHK_VACUOUS_CNT_EN
  output logic [CNT_W-1:0] impl_vac,
`endif
  output logic [CNT_W-1:0] fb_fail
);

  localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

  logic rose_a, rose_b;
  logic eval_vld, eval_ant;
  res_e impl_d, fb_d;
  res_e impl_q, fb_q;

  rose_det u_rose_a (.clk(clk), .rst(rst), .d(a), .rose(rose_a));
  rose_det u_rose_b (.clk(clk), .rst(rst), .d(b), .rose(rose_b));

  // Stage 0 of the attempt pipeline is the live {en, rose_a}; only later stages are registered.
  generate
    if (DLY == 0) begin : g_no_pipe
      assign eval_vld = en;
      assign eval_ant = rose_a;
    end else begin : g_pipe
      logic [DLY-1:0] vld_q, ant_q;

      // Shift attempts toward their evaluation cycle; reset drops everything in flight.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
          ant_q <= '0;
        end else begin
          vld_q[0] <= en;
          ant_q[0] <= rose_a;
          for (int k = 1; k < DLY; k++) begin
            vld_q[k] <= vld_q[k-1];
            ant_q[k] <= ant_q[k-1];
          end
        end
      end

      assign eval_vld = vld_q[DLY-1];
      assign eval_ant = ant_q[DLY-1];
    end
  endgenerate

  // Verdicts for the attempt reaching evaluation this cycle; followed-by fails when vacuous.
  always_comb begin
    impl_d = RES_NONE;
    fb_d   = RES_NONE;
    if (eval_vld) begin
      if (eval_ant && rose_b) begin
        impl_d = RES_PASS;
        fb_d   = RES_PASS;
      end else if (eval_ant) begin
        impl_d = RES_FAIL;
        fb_d   = RES_FAIL;
      end else begin
        impl_d = RES_VAC;
        fb_d   = RES_FAIL;
      end
    end
  end

  // Register the verdict strobe and results.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld <= 1'b0;
      impl_q  <= RES_NONE;
      fb_q    <= RES_NONE;
    end else begin
      res_vld <= eval_vld;
      impl_q  <= impl_d;
      fb_q    <= fb_d;
    end
  end

  assign impl_res = impl_q;
  assign fb_res   = fb_q;

  // Count registered verdicts; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      impl_pass <= '0;
      impl_fail <= '0;
      fb_pass   <= '0;
      fb_fail   <= '0;
    end else if (res_vld) begin
      if (impl_q == RES_PASS) impl_pass <= CNT_W'(sat_inc(SAT_W'(impl_pass), CNT_MAX));
      if (impl_q == RES_FAIL) impl_fail <= CNT_W'(sat_inc(SAT_W'(impl_fail), CNT_MAX));
      if (fb_q == RES_PASS)   fb_pass   <= CNT_W'(sat_inc(SAT_W'(fb_pass), CNT_MAX));
      if (fb_q == RES_FAIL)   fb_fail   <= CNT_W'(sat_inc(SAT_W'(fb_fail), CNT_MAX));
    end
  end

`ifdef CHK_VACUOUS_CNT_EN
  // Vacuous implication successes.
  always_ff @(posedge clk) begin
    if (rst || clr)                        impl_vac <= '0;
    else if (res_vld && impl_q == RES_VAC) impl_vac <= CNT_W'(sat_inc(SAT_W'(impl_vac), CNT_MAX));
  end
`endif

endmodule

// File: tb/tb_rose_prop_checker.sv
// Bench for rose_prop_checker: three instances (DLY=0, DLY=2, DLY=1/CNT_W=3) share the
// stimulus; a history-based model of the property is compared every cycle.
module tb_rose_prop_checker;
  import chk_pkg::*;

  localparam int N_MAX = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, clr, a, b;

  logic        d0_vld;
  logic [1:0]  d0_ir, d0_fr;
  logic [15:0] d0_ip, d0_if, d0_fp, d0_ff, d0_iv;
  logic        d2_vld;
  logic [1:0]  d2_ir, d2_fr;
  logic [15:0] d2_ip, d2_if, d2_fp, d2_ff, d2_iv;
  logic        s_vld;
  logic [1:0]  s_ir, s_fr;
  logic [2:0]  s_ip, s_if, s_fp, s_ff, s_iv;

  rose_prop_checker #(.DLY(0), .CNT_W(16)) u_d0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
    .res_vld(d0_vld), .impl_res(d0_ir), .fb_res(d0_fr),
    .impl_pass(d0_ip), .impl_fail(d0_if), .fb_pass(d0_fp),
`ifdef CHK_VACUOUS_CNT_EN
    .impl_vac(d0_iv),
`endif
    .fb_fail(d0_ff));

  rose_prop_checker #(.DLY(2), .CNT_W(16)) u_d2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
    .res_vld(d2_vld), .impl_res(d2_ir), .fb_res(d2_fr),
    .impl_pass(d2_ip), .impl_fail(d2_if), .fb_pass(d2_fp),
`ifdef CHK_VACUOUS_CNT_EN
    .impl_vac(d2_iv),
`endif
    .fb_fail(d2_ff));

  rose_prop_checker #(.DLY(1), .CNT_W(3)) u_s (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
    .res_vld(s_vld), .impl_res(s_ir), .fb_res(s_fr),
    .impl_pass(s_ip), .impl_fail(s_if), .fb_pass(s_fp),
`ifdef CHK_VACUOUS_CNT_EN
    .impl_vac(s_iv),
`endif
    .fb_fail(s_ff));

`ifndef CHK_VACUOUS_CNT_EN
  assign d0_iv = '0;
  assign d2_iv = '0;
  assign s_iv  = '0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stimulus history, indexed by the clock edge that samples it.
  bit h_a[N_MAX], h_b[N_MAX], h_en[N_MAX], h_clr[N_MAX], h_rst[N_MAX];
  int n_cyc = 0;

  int   dly_of[3]  = '{0, 2, 1};
  int   max_cnt[3] = '{65535, 65535, 7};
  int   exp_cnt[3][5];
  bit   pv_vld[3];
  res_e pv_impl[3], pv_fb[3];

  function automatic bit rose_at(input bit is_b, input int n);
    bit cur, prv;
    cur = is_b ? h_b[n] : h_a[n];
    prv = (n == 0 || h_rst[n-1]) ? 1'b0 : (is_b ? h_b[n-1] : h_a[n-1]);
    return cur & ~prv;
  endfunction

  // Verdict registered at edge n: the attempt started DLY edges earlier, if it survived.
  function automatic void calc(input int dly, input int n, output bit vld,
                               output res_e impl, output res_e fb);
    int  s;
    bit  ant, cons;
    vld  = 1'b0;
    impl = RES_NONE;
    fb   = RES_NONE;
    s    = n - dly;
    if (s < 0 || !h_en[s]) return;
    for (int k = s; k <= n; k++) if (h_rst[k]) return;
    ant  = rose_at(1'b0, s);
    cons = rose_at(1'b1, n);
    vld  = 1'b1;
    impl = ant ? (cons ? RES_PASS : RES_FAIL) : RES_VAC;
    fb   = (ant && cons) ? RES_PASS : RES_FAIL;
  endfunction

  function automatic void bump(input int i, input int k);
    if (exp_cnt[i][k] < max_cnt[i]) exp_cnt[i][k]++;
  endfunction

  task automatic check_inst(input string nm, input int i, input logic vld,
                            input logic [1:0] ir, input logic [1:0] fr,
                            input logic [31:0] ip, input logic [31:0] ifl,
                            input logic [31:0] fp, input logic [31:0] ff,
                            input logic [31:0] iv);
    chk({nm, ".res_vld"},   vld, pv_vld[i]);
    chk({nm, ".impl_res"},  ir,  pv_impl[i]);
    chk({nm, ".fb_res"},    fr,  pv_fb[i]);
    chk({nm, ".impl_pass"}, ip,  exp_cnt[i][0]);
    chk({nm, ".impl_fail"}, ifl, exp_cnt[i][1]);
    chk({nm, ".fb_pass"},   fp,  exp_cnt[i][2]);
    chk({nm, ".fb_fail"},   ff,  exp_cnt[i][3]);
`ifdef CHK_VACUOUS_CNT_EN
    chk({nm, ".impl_vac"},  iv,  exp_cnt[i][4]);
`endif
  endtask

  task automatic model_and_check(input int n);
    bit   vld;
    res_e im, fb;
    for (int i = 0; i < 3; i++) begin
      calc(dly_of[i], n, vld, im, fb);
      if (h_rst[n] || h_clr[n]) begin
        for (int k = 0; k < 5; k++) exp_cnt[i][k] = 0;
      end else if (pv_vld[i]) begin
        if (pv_impl[i] == RES_PASS) bump(i, 0);
        if (pv_impl[i] == RES_FAIL) bump(i, 1);
        if (pv_fb[i] == RES_PASS)   bump(i, 2);
        if (pv_fb[i] == RES_FAIL)   bump(i, 3);
        if (pv_impl[i] == RES_VAC)  bump(i, 4);
      end
      pv_vld[i]  = vld;
      pv_impl[i] = im;
      pv_fb[i]   = fb;
    end
    check_inst("d0", 0, d0_vld, d0_ir, d0_fr, d0_ip, d0_if, d0_fp, d0_ff, d0_iv);
    check_inst("d2", 1, d2_vld, d2_ir, d2_fr, d2_ip, d2_if, d2_fp, d2_ff, d2_iv);
    check_inst("s",  2, s_vld,  s_ir,  s_fr,  s_ip,  s_if,  s_fp,  s_ff,  s_iv);
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare on the falling edge.
  task automatic tick(input bit ia, input bit ib, input bit ien, input bit iclr, input bit irst);
    a = ia; b = ib; en = ien; clr = iclr; rst = irst;
    h_a[n_cyc] = ia; h_b[n_cyc] = ib; h_en[n_cyc] = ien;
    h_clr[n_cyc] = iclr; h_rst[n_cyc] = irst;
    @(posedge clk);
    @(negedge clk);
    model_and_check(n_cyc);
    n_cyc++;
  endtask

  task automatic do_reset();
    tick(0, 0, 1, 0, 1);
    tick(0, 0, 1, 0, 1);
  endtask

  initial begin
    // Scenario 1: DLY=0, both rise together on cycle 3.
    do_reset();
    chk("rst.d0.res_vld", d0_vld, 1'b0);
    chk("rst.d0.impl_res", d0_ir, RES_NONE);
    for (int c = 0; c < 11; c++) begin
      tick(c >= 3, c >= 3, 1, 0, 0);
      if (c < 3) begin
        chk("s1.vac_impl", d0_ir, RES_VAC);
        chk("s1.vac_fb", d0_fr, RES_FAIL);
      end
      if (c == 3) begin
        chk("s1.pass_vld", d0_vld, 1'b1);
        chk("s1.pass_impl", d0_ir, RES_PASS);
        chk("s1.pass_fb", d0_fr, RES_PASS);
      end
    end
    chk("s1.fb_fail", d0_ff, 9);
    chk("s1.fb_pass", d0_fp, 1);
    chk("s1.impl_pass", d0_ip, 1);
    chk("s1.impl_fail", d0_if, 0);
`ifdef CHK_VACUOUS_CNT_EN
    chk("s1.impl_vac", d0_iv, 9);
`endif

    // Scenario 2: DLY=0, a rises on cycle 2 with b low.
    do_reset();
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(1, 0, 1, 0, 0);
    chk("s2.impl_res", d0_ir, RES_FAIL);
    chk("s2.fb_res", d0_fr, RES_FAIL);
    tick(1, 0, 1, 0, 0);
    chk("s2.impl_fail", d0_if, 1);

    // Scenario 3: DLY=2, a rises on cycle 1, b on cycle 3.
    do_reset();
    chk("s3.fill0", d2_vld, 1'b0);
    tick(0, 0, 1, 0, 0);
    chk("s3.fill1", d2_vld, 1'b0);
    tick(1, 0, 1, 0, 0);
    chk("s3.fill2", d2_vld, 1'b0);
    tick(1, 0, 1, 0, 0);
    tick(1, 1, 1, 0, 0);
    chk("s3.impl_res", d2_ir, RES_PASS);
    chk("s3.fb_res", d2_fr, RES_PASS);

    // Scenario 4: CNT_W=3 saturation, then clear against a live increment.
    do_reset();
    for (int c = 0; c < 12; c++) tick(1'($urandom_range(1)), 0, 1, 0, 0);
    chk("s4.fb_fail_sat", s_ff, 7);
    tick(0, 0, 1, 1, 0);
    chk("s4.fb_fail_clr", s_ff, 0);
    tick(0, 0, 1, 0, 0);
    chk("s4.fb_fail_after", s_ff, 1);

    // Scenario 5: DLY=2, reset while an attempt is in flight.
    do_reset();
    tick(0, 0, 1, 0, 0);
    tick(1, 0, 1, 0, 0);
    tick(1, 1, 1, 0, 1);
    for (int c = 0; c < 4; c++) begin
      tick(1, 1, 0, 0, 0);
      chk("s5.res_vld", d2_vld, 1'b0);
      chk("s5.fb_fail", d2_ff, 0);
      chk("s5.impl_pass", d2_ip, 0);
    end

    // Random traffic with occasional clear and reset.
    while (n_cyc < 3000) begin
      tick(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(7) != 0,
           $urandom_range(31) == 0, $urandom_range(63) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
